// File: rtl/mem_phase_sequencer_if.sv
// Bundle of UART RX/TX, processor and BRAM signals around the image-memory sequencer.
// master = sequencer side, slave = surrounding UART/processor/BRAM side.
interface mem_phase_sequencer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              tx_done;
  logic [ADDR_W-1:0] pro_addr;
  logic [DATA_W-1:0] pro_dout;
  logic              pro_we;
  logic              pro_over;
  logic [DATA_W-1:0] mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              pro_rst;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              rx_finish;
  logic              tx_finish;

  modport master (
    input  rx_done, rx_data, tx_done, pro_addr, pro_dout, pro_we, pro_over, mem_dout,
    output mem_addr, mem_din, mem_we, pro_rst, tx_start, tx_data, rx_finish, tx_finish
  );

  modport slave (
    output rx_done, rx_data, tx_done, pro_addr, pro_dout, pro_we, pro_over, mem_dout,
    input  mem_addr, mem_din, mem_we, pro_rst, tx_start, tx_data, rx_finish, tx_finish
  );
endinterface

// File: rtl/mem_phase_sequencer.sv
// Time-shares the image BRAM across UART RX, processor and UART TX phases.
// Define SEQ_RESTART_EN to let an rx_done in DONE start a new run.
module mem_phase_sequencer #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int IN_BASE  = 7,
  parameter int IN_SIZE  = 65536,
  parameter int OUT_BASE = 65543,
  parameter int OUT_SIZE = 16257,
  parameter int READ_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  mem_phase_sequencer_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  IN_SIZE_C  = CNT_W'(IN_SIZE);
  localparam logic [CNT_W-1:0]  OUT_SIZE_C = CNT_W'(OUT_SIZE);
  localparam logic [CNT_W-1:0]  IN_BASE_C  = CNT_W'(IN_BASE);
  localparam logic [CNT_W-1:0]  OUT_BASE_C = CNT_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] IN_ADDR0   = ADDR_W'(IN_BASE);
  localparam logic [1:0]        LAT_C      = 2'(READ_LAT);

  typedef enum logic [2:0] {RX, PROC, TX_ADDR, TX_WAIT, TX_GO, TX_BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  rx_cnt_reg, rx_cnt_next;
  logic [CNT_W-1:0]  tx_cnt_reg, tx_cnt_next;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic              wr_pending_reg, wr_pending_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic              rx_finish_reg, rx_finish_next;
  logic              tx_finish_reg, tx_finish_next;

  logic [CNT_W-1:0]  rx_sum;
  logic [CNT_W-1:0]  tx_sum;
  logic              last_write;

  // A byte arriving during the pending write lands one address further on.
  assign rx_sum     = IN_BASE_C + rx_cnt_reg + CNT_W'(wr_pending_reg);
  assign tx_sum     = OUT_BASE_C + tx_cnt_reg;
  assign last_write = wr_pending_reg && (rx_cnt_reg == IN_SIZE_C - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RX;
      rx_cnt_reg     <= '0;
      tx_cnt_reg     <= '0;
      lat_cnt_reg    <= '0;
      wr_pending_reg <= 1'b0;
      wr_addr_reg    <= IN_ADDR0;
      wr_data_reg    <= '0;
      tx_data_reg    <= '0;
      rx_finish_reg  <= 1'b0;
      tx_finish_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rx_cnt_reg     <= rx_cnt_next;
      tx_cnt_reg     <= tx_cnt_next;
      lat_cnt_reg    <= lat_cnt_next;
      wr_pending_reg <= wr_pending_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      tx_data_reg    <= tx_data_next;
      rx_finish_reg  <= rx_finish_next;
      tx_finish_reg  <= tx_finish_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rx_cnt_next     = rx_cnt_reg;
    tx_cnt_next     = tx_cnt_reg;
    lat_cnt_next    = lat_cnt_reg;
    wr_pending_next = wr_pending_reg;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    tx_data_next    = tx_data_reg;
    rx_finish_next  = rx_finish_reg;
    tx_finish_next  = tx_finish_reg;
    bus.mem_addr    = tx_sum[ADDR_W-1:0];
    bus.mem_din     = '0;
    bus.mem_we      = 1'b0;
    bus.pro_rst     = 1'b0;
    bus.tx_start    = 1'b0;

    case (state_reg)
      RX: begin
        bus.pro_rst     = 1'b1;
        bus.mem_addr    = wr_addr_reg;
        bus.mem_din     = wr_data_reg;
        bus.mem_we      = wr_pending_reg;
        wr_pending_next = 1'b0;
        if (wr_pending_reg)
          rx_cnt_next = rx_cnt_reg + 1'b1;
        if (last_write) begin
          state_next     = PROC;
          rx_finish_next = 1'b1;
        end else if (bus.rx_done) begin
          wr_pending_next = 1'b1;
          wr_addr_next    = rx_sum[ADDR_W-1:0];
          wr_data_next    = bus.rx_data;
        end
      end
      PROC: begin
        bus.mem_addr = bus.pro_addr;
        bus.mem_din  = bus.pro_dout;
        bus.mem_we   = bus.pro_we;
        if (bus.pro_over)
          state_next = TX_ADDR;
      end
      TX_ADDR: begin
        lat_cnt_next = '0;
        state_next   = TX_WAIT;
      end
      TX_WAIT: begin
        // Address held READ_LAT+1 cycles so the sample lands after the BRAM output settles.
        if (lat_cnt_reg == LAT_C) begin
          tx_data_next = bus.mem_dout;
          state_next   = TX_GO;
        end else begin
          lat_cnt_next = lat_cnt_reg + 1'b1;
        end
      end
      TX_GO: begin
        bus.tx_start = 1'b1;
        state_next   = TX_BUSY;
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
          if (tx_cnt_reg + 1'b1 == OUT_SIZE_C) begin
            state_next     = DONE;
            tx_finish_next = 1'b1;
          end else begin
            state_next = TX_ADDR;
          end
        end
      end
      DONE: begin
`ifdef SEQ_RESTART_EN
        if (bus.rx_done) begin
          state_next      = RX;
          rx_cnt_next     = '0;
          tx_cnt_next     = '0;
          lat_cnt_next    = '0;
          rx_finish_next  = 1'b0;
          tx_finish_next  = 1'b0;
          wr_pending_next = 1'b1;
          wr_addr_next    = IN_ADDR0;
          wr_data_next    = bus.rx_data;
        end
`else
        state_next = DONE;
`endif
      end
      default: state_next = RX;
    endcase
  end

  assign bus.tx_data   = tx_data_reg;
  assign bus.rx_finish = rx_finish_reg;
  assign bus.tx_finish = tx_finish_reg;
endmodule

// File: tb/tb_mem_phase_sequencer.sv
// Directed bench for mem_phase_sequencer with a small BRAM model (READ_LAT=2).
module tb_mem_phase_sequencer;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  logic [7:0] bram [0:511];
  logic [7:0] rd0, rd1;

  mem_phase_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_phase_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_BASE(7), .IN_SIZE(4),
    .OUT_BASE(20), .OUT_SIZE(2), .READ_LAT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we)
      bram[bus.mem_addr[8:0]] <= bus.mem_din;
    rd0 <= bram[bus.mem_addr[8:0]];
    rd1 <= rd0;
  end
  assign bus.mem_dout = rd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int cycles);
    cycles = 0;
    while (bus.tx_start !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_rx(input logic [7:0] base);
    bus.rx_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.rx_data = base + 8'(k);
      tick();
    end
    bus.rx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.mem_addr !== 18'd7) begin bad++; $display("FAIL reset_mem_addr got=%0d want=7", bus.mem_addr); end
    total++; if (bus.mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got=%h want=00", bus.mem_din); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); end
    total++; if (bus.pro_rst !== 1'b1) begin bad++; $display("FAIL reset_pro_rst got=%b want=1", bus.pro_rst); end
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
    total++; if ({bus.rx_finish, bus.tx_finish} !== 2'b00) begin bad++; $display("FAIL reset_finish got=%b want=00", {bus.rx_finish, bus.tx_finish}); end
    $display("reset: mem_addr=%0d pro_rst=%b", bus.mem_addr, bus.pro_rst);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ignore_in_rx();
    bus.tx_done  = 1'b1;
    bus.pro_we   = 1'b1;
    bus.pro_addr = 18'h100;
    bus.pro_dout = 8'h5A;
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rx_pro_we_blocked got=%b want=0", bus.mem_we); end
    tick();
    bus.tx_done = 1'b0;
    bus.pro_we  = 1'b0;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rx_tx_done_ignored_we got=%b want=0", bus.mem_we); end
    total++; if (bus.pro_rst !== 1'b1 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL rx_tx_done_ignored pro_rst=%b tx_start=%b want 1,0", bus.pro_rst, bus.tx_start); end
    total++; if (bus.mem_addr !== 18'd7) begin bad++; $display("FAIL rx_tx_done_addr got=%0d want=7", bus.mem_addr); end
    $display("ignore in RX: mem_we=%b pro_rst=%b", bus.mem_we, bus.pro_rst);
  endtask

  task automatic test_rx();
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hA1;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rx_we[%0d] got=%b want=1", k, bus.mem_we); end
      total++; if (bus.mem_addr !== 18'(7 + k)) begin bad++; $display("FAIL rx_addr[%0d] got=%0d want=%0d", k, bus.mem_addr, 7 + k); end
      total++; if (bus.mem_din !== 8'(8'hA1 + k)) begin bad++; $display("FAIL rx_din[%0d] got=%h want=%h", k, bus.mem_din, 8'(8'hA1 + k)); end
      $display("rx write %0d: addr=%0d din=%h", k, bus.mem_addr, bus.mem_din);
      if (k < 3) begin
        bus.rx_data = 8'(8'hA2 + k);
        tick();
      end else begin
        bus.rx_done = 1'b0;
      end
    end
    total++; if (bus.pro_rst !== 1'b1 || bus.rx_finish !== 1'b0) begin bad++; $display("FAIL rx_last_cycle pro_rst=%b rx_finish=%b want 1,0", bus.pro_rst, bus.rx_finish); end
    tick();
    total++; if (bus.rx_finish !== 1'b1) begin bad++; $display("FAIL rx_finish got=%b want=1", bus.rx_finish); end
    total++; if (bus.pro_rst !== 1'b0) begin bad++; $display("FAIL proc_pro_rst got=%b want=0", bus.pro_rst); end
    total++; if (bram[9] !== 8'hA3) begin bad++; $display("FAIL bram9 got=%h want=a3", bram[9]); end
    $display("rx done: rx_finish=%b pro_rst=%b", bus.rx_finish, bus.pro_rst);
  endtask

  task automatic test_proc();
    bus.pro_addr = 18'h100;
    bus.pro_dout = 8'h5A;
    bus.pro_we   = 1'b1;
    bus.rx_done  = 1'b1;
    bus.rx_data  = 8'hEE;
    #1;
    total++; if (bus.mem_addr !== 18'h100) begin bad++; $display("FAIL proc_addr got=%h want=100", bus.mem_addr); end
    total++; if (bus.mem_din !== 8'h5A) begin bad++; $display("FAIL proc_din got=%h want=5a", bus.mem_din); end
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL proc_we got=%b want=1", bus.mem_we); end
    tick();
    bus.pro_we  = 1'b0;
    bus.rx_done = 1'b0;
    #1;
    total++; if (bus.mem_we !== 1'b0 || bram[256] !== 8'h5A) begin bad++; $display("FAIL proc_write we=%b bram=%h want 0,5a", bus.mem_we, bram[256]); end
    bus.pro_over = 1'b1;
    tick();
    bus.pro_over = 1'b0;
    total++; if (bus.mem_addr !== 18'd20 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL tx_addr0 addr=%0d we=%b want 20,0", bus.mem_addr, bus.mem_we); end
    $display("proc: mirrored write, now TX addr=%0d", bus.mem_addr);
  endtask

  task automatic test_tx();
    wait_start(n);
    total++; if (n !== 4) begin bad++; $display("FAIL tx0_latency got=%0d want=4", n); end
    total++; if (bus.tx_data !== 8'h33) begin bad++; $display("FAIL tx0_data got=%h want=33", bus.tx_data); end
    $display("tx byte 0: data=%h after %0d cycles", bus.tx_data, n);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL tx_start_one_cycle got=%b want=0", bus.tx_start); end
    tick();
    tick();
    total++; if (bus.mem_addr !== 18'd20) begin bad++; $display("FAIL tx_done_in_go_ignored addr=%0d want=20", bus.mem_addr); end
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h55;
    tick();
    bus.rx_done = 1'b0;
    total++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 18'd20) begin bad++; $display("FAIL tx_rx_ignored we=%b addr=%0d want 0,20", bus.mem_we, bus.mem_addr); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++; if (bus.mem_addr !== 18'd21) begin bad++; $display("FAIL tx1_addr got=%0d want=21", bus.mem_addr); end
    wait_start(n);
    total++; if (n !== 4) begin bad++; $display("FAIL tx1_latency got=%0d want=4", n); end
    total++; if (bus.tx_data !== 8'h44) begin bad++; $display("FAIL tx1_data got=%h want=44", bus.tx_data); end
    $display("tx byte 1: data=%h after %0d cycles", bus.tx_data, n);
    tick();
    total++; if (bus.tx_finish !== 1'b0) begin bad++; $display("FAIL tx_finish_early got=%b want=0", bus.tx_finish); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++; if (bus.tx_finish !== 1'b1 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL tx_finish fin=%b start=%b want 1,0", bus.tx_finish, bus.tx_start); end
    $display("tx done: tx_finish=%b", bus.tx_finish);
  endtask

  task automatic test_done();
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h77;
    tick();
    bus.rx_done = 1'b0;
`ifdef SEQ_RESTART_EN
    total++; if (bus.pro_rst !== 1'b1) begin bad++; $display("FAIL restart_pro_rst got=%b want=1", bus.pro_rst); end
    total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 18'd7 || bus.mem_din !== 8'h77) begin bad++; $display("FAIL restart_write we=%b addr=%0d din=%h want 1,7,77", bus.mem_we, bus.mem_addr, bus.mem_din); end
    total++; if (bus.tx_finish !== 1'b0 || bus.rx_finish !== 1'b0) begin bad++; $display("FAIL restart_flags tx=%b rx=%b want 0,0", bus.tx_finish, bus.rx_finish); end
`else
    total++; if (bus.mem_we !== 1'b0 || bus.pro_rst !== 1'b0) begin bad++; $display("FAIL done_ignore we=%b pro_rst=%b want 0,0", bus.mem_we, bus.pro_rst); end
    total++; if (bus.tx_finish !== 1'b1) begin bad++; $display("FAIL done_stays got=%b want=1", bus.tx_finish); end
`endif
    $display("done + rx_done: pro_rst=%b mem_we=%b", bus.pro_rst, bus.mem_we);
  endtask

  task automatic test_reset_mid_tx();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_rx(8'hB0);
    bus.pro_over = 1'b1;
    tick();
    bus.pro_over = 1'b0;
    wait_start(n);
    tick();
    total++; if (bus.tx_data !== 8'h33) begin bad++; $display("FAIL midtx_pre_data got=%h want=33", bus.tx_data); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.tx_data !== 8'h00 || bus.mem_addr !== 18'd7) begin bad++; $display("FAIL midtx_reset data=%h addr=%0d want 00,7", bus.tx_data, bus.mem_addr); end
    total++; if (bus.pro_rst !== 1'b1 || bus.mem_we !== 1'b0 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL midtx_reset_ctl pro_rst=%b we=%b start=%b want 1,0,0", bus.pro_rst, bus.mem_we, bus.tx_start); end
    total++; if ({bus.rx_finish, bus.tx_finish} !== 2'b00) begin bad++; $display("FAIL midtx_reset_flags got=%b want=00", {bus.rx_finish, bus.tx_finish}); end
    tick();
    rst_n = 1'b1;
    tick();
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h99;
    tick();
    bus.rx_done = 1'b0;
    total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 18'd7 || bus.mem_din !== 8'h99) begin bad++; $display("FAIL resume_rx we=%b addr=%0d din=%h want 1,7,99", bus.mem_we, bus.mem_addr, bus.mem_din); end
    $display("reset mid-TX: resumed write addr=%0d din=%h", bus.mem_addr, bus.mem_din);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) bram[i] = 8'h00;
    bram[20] = 8'h33;
    bram[21] = 8'h44;
    bus.rx_done  = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_done  = 1'b0;
    bus.pro_addr = '0;
    bus.pro_dout = 8'h00;
    bus.pro_we   = 1'b0;
    bus.pro_over = 1'b0;
    test_reset();
    test_ignore_in_rx();
    test_rx();
    test_proc();
    test_tx();
    test_done();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
